// File: rtl/vedic_divider_pkg.sv
// Shared types and constants for the 8-by-4 bit sequential flag-digit divider.
// Widths are fixed; the error-saturation values are what a faulted division reports.
package vedic_divider_pkg;

    localparam int DVD_W   = 8;
    localparam int DVS_W   = 4;
    localparam int Q_W     = 5;
    localparam int R_W     = 4;
    localparam int PR_W    = 5;
    localparam int N_STEPS = 5;

    localparam logic [2:0]     LAST_STEP = 3'd4;
    localparam logic [Q_W-1:0] Q_SAT     = 5'h1F;
    localparam logic [R_W-1:0] R_SAT     = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // The quotient needs more than 5 bits exactly when the top three dividend bits already reach the divisor.
    function automatic logic div_fault(input logic [2:0] dvd_hi, input logic [DVS_W-1:0] dvs);
        return (dvs == 4'd0) || ({1'b0, dvd_hi} >= dvs);
    endfunction

endpackage

// File: rtl/vedic_div_step.sv
// One combinational flag-digit step: append the next dividend bit to the partial
// remainder, then subtract the divisor when it fits.
module vedic_div_step
    import vedic_divider_pkg::*;
(
    input  logic [PR_W-1:0]  pr_in,
    input  logic             dvd_bit,
    input  logic [DVS_W-1:0] divisor,
    output logic [PR_W-1:0]  pr_out,
    output logic             q_bit
);

    logic [PR_W:0] shifted_s;
    logic [PR_W:0] diff_s;

    assign shifted_s = {pr_in, dvd_bit};
    assign diff_s    = shifted_s - {2'b00, divisor};

    // Compare/subtract; the upper bit only matters in the overflow case, whose result is discarded.
    always_comb begin
        pr_out = shifted_s[PR_W-1:0];
        q_bit  = 1'b0;
        if (shifted_s >= {2'b00, divisor}) begin
            pr_out = diff_s[PR_W-1:0];
            q_bit  = 1'b1;
        end else begin
            pr_out = shifted_s[PR_W-1:0];
            q_bit  = 1'b0;
        end
    end

endmodule

// File: rtl/vedic_divider.sv
// Sequential unsigned divider: resolves one quotient bit per clock, MSB first,
// behind a start/done handshake. Errors are decided when the operands are captured.
module vedic_divider
    import vedic_divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient,
    output logic [R_W-1:0]   remainder,
    output logic             div_err
);

    state_t           state_r;
    state_t           state_nx_s;
    logic [2:0]       step_r;
    logic [PR_W-1:0]  pr_r;
    logic [4:0]       bits_r;
    logic [DVS_W-1:0] dvs_r;
    logic [3:0]       q_acc_r;
    logic             err_r;

    logic             busy_r;
    logic             done_r;
    logic [Q_W-1:0]   quotient_r;
    logic [R_W-1:0]   remainder_r;
    logic             div_err_r;

    logic [PR_W-1:0]  pr_nx_s;
    logic             q_bit_s;

    vedic_div_step u_step (
        .pr_in   (pr_r),
        .dvd_bit (bits_r[4]),
        .divisor (dvs_r),
        .pr_out  (pr_nx_s),
        .q_bit   (q_bit_s)
    );

    // Next-state logic for the IDLE -> ITER -> DONE sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = ITER;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ITER: begin
                if (step_r == LAST_STEP) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = ITER;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State, iteration datapath and registered handshake/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            step_r      <= 3'd0;
            pr_r        <= 5'd0;
            bits_r      <= 5'd0;
            dvs_r       <= 4'd0;
            q_acc_r     <= 4'd0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= 5'd0;
            remainder_r <= 4'd0;
            div_err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ITER);
            done_r  <= (state_nx_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        pr_r    <= {2'b00, dividend[7:5]};
                        bits_r  <= dividend[4:0];
                        dvs_r   <= divisor;
                        step_r  <= 3'd0;
                        q_acc_r <= 4'd0;
                        err_r   <= div_fault(dividend[7:5], divisor);
                    end
                end
                ITER: begin
                    pr_r    <= pr_nx_s;
                    bits_r  <= {bits_r[3:0], 1'b0};
                    q_acc_r <= {q_acc_r[2:0], q_bit_s};
                    step_r  <= step_r + 3'd1;
                    if (step_r == LAST_STEP) begin
                        if (err_r) begin
                            quotient_r  <= Q_SAT;
                            remainder_r <= R_SAT;
                            div_err_r   <= 1'b1;
                        end else begin
                            quotient_r  <= {q_acc_r, q_bit_s};
                            remainder_r <= pr_nx_s[R_W-1:0];
                            div_err_r   <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign div_err   = div_err_r;

endmodule

// File: tb/tb_vedic_divider.sv
// Self-checking bench for vedic_divider: directed cases plus random operands,
// compared against plain integer division.
module tb_vedic_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [4:0] quotient;
    logic [3:0] remainder;
    logic       div_err;

    int n_err = 0;
    int n_chk = 0;

    logic [4:0] prev_q = 5'd0;
    logic [3:0] prev_r = 4'd0;
    logic       prev_e = 1'b0;

    vedic_divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_err   (div_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [7:0] a, input logic [3:0] b,
                         output logic [4:0] q, output logic [3:0] r, output logic e);
        int iq;
        if (b == 4'd0) begin
            q = 5'd31; r = 4'd15; e = 1'b1;
        end else begin
            iq = int'(a) / int'(b);
            if (iq > 31) begin
                q = 5'd31; r = 4'd15; e = 1'b1;
            end else begin
                q = 5'(iq);
                r = 4'(int'(a) % int'(b));
                e = 1'b0;
            end
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit poke);
        int lat;
        int extra;
        logic [4:0] mq;
        logic [3:0] mr;
        logic       me;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_on_accept", busy, 1);
        check("q_hold_on_start", quotient, prev_q);
        check("r_hold_on_start", remainder, prev_r);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (poke && lat == 1) begin
                start    = 1'b1;
                dividend = ~a;
                divisor  = b + 4'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        model(a, b, mq, mr, me);
        check("latency", lat, 5);
        check("quotient", quotient, mq);
        check("remainder", remainder, mr);
        check("div_err", div_err, me);
        check("busy_in_done", busy, 0);
        prev_q = mq;
        prev_r = mr;
        prev_e = me;
        @(posedge clk);
        #1;
        check("done_single_pulse", done, 0);
        if (poke) begin
            extra = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) extra++;
            end
            check("no_extra_done", extra, 0);
        end
    endtask

    initial begin
        int stray;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_err", div_err, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'd241, 4'd14, 1'b0);
        run_op(8'd200, 4'd8, 1'b0);
        run_op(8'd204, 4'd8, 1'b0);
        run_op(8'd234, 4'd8, 1'b0);
        run_op(8'h55, 4'd0, 1'b0);
        run_op(8'd255, 4'd3, 1'b0);
        run_op(8'd95, 4'd3, 1'b0);
        run_op(8'd0, 4'd15, 1'b0);
        run_op(8'd100, 4'd7, 1'b1);

        // Abort mid-iteration with an off-edge reset.
        @(negedge clk);
        dividend = 8'd77;
        divisor  = 4'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_err", div_err, 0);
        @(negedge clk);
        rst = 1'b0;
        prev_q = 5'd0;
        prev_r = 4'd0;
        prev_e = 1'b0;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) stray++;
        end
        check("abort_no_done", stray, 0);
        run_op(8'd123, 4'd5, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_op(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
